// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: WIDTH-bit universal shift register with a handshake-started burst-shift engine; `define USR_PARITY_EN adds a registered Parity output
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       select,
    input  logic             SerInMsb,
    input  logic             SerInLsb,
    input  logic             Start,
    input  logic [CNT_W-1:0] Amount,
    input  logic             Dir,
    input  logic             Rot,
    output logic [WIDTH-1:0] A,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
`ifdef USR_PARITY_EN
    ,
    output logic             Parity
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d, rot_q, rot_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             ser_q, ser_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] shr, shl, rotr, rotl, asr;

    // candidate one-bit moves of the current contents
    always_comb begin
        shr  = {SerInMsb, a_q[WIDTH-1:1]};
        shl  = {a_q[WIDTH-2:0], SerInLsb};
        rotr = {a_q[0], a_q[WIDTH-1:1]};
        rotl = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        asr  = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    end

    // mode decode in IDLE, burst sequencing in SHIFT, one-cycle Done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        a_d     = a_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    dir_d   = Dir;
                    rot_d   = Rot;
                    cnt_d   = Amount;
                    state_d = (Amount == '0) ? DONE : SHIFT;
                end else begin
                    case (select)
                        3'b001: begin a_d = shr;  ser_d = a_q[0];       end
                        3'b010: begin a_d = shl;  ser_d = a_q[WIDTH-1]; end
                        3'b011: a_d = I;
                        3'b100: begin a_d = rotr; ser_d = a_q[0];       end
                        3'b101: begin a_d = rotl; ser_d = a_q[WIDTH-1]; end
                        3'b110: begin a_d = asr;  ser_d = a_q[0];       end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                a_d   = dir_q ? (rot_q ? rotl : shl) : (rot_q ? rotr : shr);
                ser_d = dir_q ? a_q[WIDTH-1] : a_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // state and datapath registers; reset aborts any burst without Done
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            a_q     <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            a_q     <= a_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A      = a_q;
    assign SerOut = ser_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

`ifdef USR_PARITY_EN
    logic par_q, par_d;

    // parity of the next contents so it lands in the same cycle as A
    always_comb par_d = ^a_d;

    // parity register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign Parity = par_q;
`endif
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// tb_universal_shift_reg_n: directed plan plus random stimulus against a behavioural model
module tb_universal_shift_reg_n;
    localparam int W = 8;
    localparam int C = 4;

    logic         Clk, Rst_n;
    logic [W-1:0] I;
    logic [2:0]   select;
    logic         SerInMsb, SerInLsb, Start, Dir, Rot;
    logic [C-1:0] Amount;
    logic [W-1:0] A;
    logic         SerOut, Busy, Done;
`ifdef USR_PARITY_EN
    logic         Parity;
`endif

    universal_shift_reg_n #(.WIDTH(W), .CNT_W(C)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .I(I), .select(select),
        .SerInMsb(SerInMsb), .SerInLsb(SerInLsb), .Start(Start),
        .Amount(Amount), .Dir(Dir), .Rot(Rot),
        .A(A), .SerOut(SerOut), .Busy(Busy), .Done(Done)
`ifdef USR_PARITY_EN
        , .Parity(Parity)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] m_a;
    logic         m_so, m_dir, m_rot;
    bit           m_busy, m_done;
    int           m_rem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 right fill, 1 left fill, 2 rotate right, 3 rotate left, 4 arithmetic right
    task automatic do_shift(input int kind);
        logic [W-1:0] top;
        top = W'(1) << (W - 1);
        case (kind)
            0: begin m_so = m_a[0];   m_a = (m_a >> 1) | (SerInMsb ? top : '0); end
            1: begin m_so = m_a[W-1]; m_a = (m_a << 1) | W'(SerInLsb); end
            2: begin m_so = m_a[0];   m_a = (m_a >> 1) | (m_a[0] ? top : '0); end
            3: begin m_so = m_a[W-1]; m_a = (m_a << 1) | W'(m_a[W-1]); end
            default: begin m_so = m_a[0]; m_a = W'($signed(m_a) >>> 1); end
        endcase
    endtask

    task automatic model_edge();
        if (m_done) m_done = 0;
        else if (m_busy) begin
            do_shift(m_dir ? (m_rot ? 3 : 1) : (m_rot ? 2 : 0));
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end else if (Start) begin
            m_dir = Dir;
            m_rot = Rot;
            m_rem = int'(Amount);
            if (m_rem == 0) m_done = 1; else m_busy = 1;
        end else begin
            case (select)
                3'd1: do_shift(0);
                3'd2: do_shift(1);
                3'd3: m_a = I;
                3'd4: do_shift(2);
                3'd5: do_shift(3);
                3'd6: do_shift(4);
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        chk("A", 32'(A), 32'(m_a));
        chk("SerOut", 32'(SerOut), 32'(m_so));
        chk("Busy", 32'(Busy), 32'(m_busy));
        chk("Done", 32'(Done), 32'(m_done));
`ifdef USR_PARITY_EN
        chk("Parity", 32'(Parity), 32'(^m_a));
`endif
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #2;
        chk("rst_A", 32'(A), 0);
        chk("rst_SerOut", 32'(SerOut), 0);
        chk("rst_Busy", 32'(Busy), 0);
        chk("rst_Done", 32'(Done), 0);
        m_a = '0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0;
        Rst_n = 1'b1;
    endtask

    task automatic load(input logic [W-1:0] v);
        Start = 0; select = 3'b011; I = v;
        tick();
    endtask

    task automatic burst(input int amt, input logic d, input logic r);
        Start = 1; select = 3'b000; Amount = C'(amt); Dir = d; Rot = r;
        tick();
        Start = 0;
    endtask

    initial begin
        I = '0; select = '0; SerInMsb = 0; SerInLsb = 0;
        Start = 0; Amount = '0; Dir = 0; Rot = 0;
        Rst_n = 1'b1;
        #1;
        do_reset();

        load(8'hA5);                        chk("load_A5", 32'(A), 32'hA5);
        select = 3'b001; SerInMsb = 1; tick();
        chk("shr_A", 32'(A), 32'hD2);       chk("shr_so", 32'(SerOut), 1);
        select = 3'b010; SerInLsb = 0; tick();
        chk("shl_A", 32'(A), 32'hA4);       chk("shl_so", 32'(SerOut), 1);
        select = 3'b011; I = 8'h00; Start = 0;
        select = 3'b000; tick();            chk("hold_so", 32'(SerOut), 1);

        load(8'h81);
        select = 3'b100; tick();            chk("ror", 32'(A), 32'hC0);
        select = 3'b101; tick();            chk("rol", 32'(A), 32'h81);
        load(8'h80);
        select = 3'b110; tick();            chk("asr1", 32'(A), 32'hC0);
        tick();                             chk("asr2", 32'(A), 32'hE0);
        select = 3'b111; tick();            chk("reserved", 32'(A), 32'hE0);

        load(8'h01);
        burst(3, 1, 1);                     chk("b_busy0", 32'(Busy), 1);
        for (int k = 0; k < 3; k++) begin
            Start = 1; Amount = 4'd7; select = 3'b011; I = 8'hFF;
            tick();
            chk("b_rot", 32'(A), 32'(8'h01 << (k + 1)));
        end
        chk("b_done", 32'(Done), 1);        chk("b_busy_end", 32'(Busy), 0);
        tick();                             chk("b_done_pulse", 32'(Done), 0);
        chk("b_start_ignored", 32'(Busy), 0);
        Start = 0; select = 3'b000;

        burst(0, 0, 0);                     chk("amt0_done", 32'(Done), 1);
        chk("amt0_A", 32'(A), 32'h08);
        tick();                             chk("amt0_pulse", 32'(Done), 0);

        load(8'h3C);
        burst(8, 0, 1);
        for (int k = 0; k < 8; k++) tick();
        chk("rot8_A", 32'(A), 32'h3C);      chk("rot8_done", 32'(Done), 1);
        tick();

        SerInMsb = 1;
        burst(9, 0, 0);
        for (int k = 0; k < 9; k++) tick();
        chk("fill9_A", 32'(A), 32'hFF);     chk("fill9_done", 32'(Done), 1);
        tick();

        load(8'h55);
        burst(5, 0, 1);
        tick();
        tick();
        do_reset();
        select = 3'b000; tick();            chk("post_rst_hold", 32'(A), 0);

`ifdef USR_PARITY_EN
        load(8'h07);                        chk("par_07", 32'(Parity), 1);
        select = 3'b010; SerInLsb = 1; tick();
        chk("par_A", 32'(A), 32'h0F);       chk("par_0F", 32'(Parity), 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            I        = W'($urandom);
            select   = 3'($urandom);
            SerInMsb = 1'($urandom);
            SerInLsb = 1'($urandom);
            Start    = ($urandom_range(0, 7) == 0);
            Amount   = C'($urandom);
            Dir      = 1'($urandom);
            Rot      = 1'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
